exec_unit: RTL and testbench

Parametrised execute stage that replaces the fixed add/pass ALU with an opcode-selected integer ALU. It resolves jumps and conditional branches in a single cycle, drives data-memory addresses for load/store, and adds an optional iterative multiplier that stalls the pipeline while busy. It sits between the decode stage and the memory/writeback stage, and registers its decode-side inputs like every other pipe stage.

---
 rtl/exec_unit_pkg.sv | 26 ++
 rtl/exec_mul_iter.sv | 63 ++++++
 rtl/exec_unit.sv | 218 +++++++++++++++++++++
 tb/tb_exec_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, branch-mask bit
// positions and the iterative-multiplier FSM encoding.
package exec_unit_pkg;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_AND   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_XOR   = 4;
  localparam int OP_SHL   = 5;
  localparam int OP_SHR   = 6;
  localparam int OP_SRA   = 7;
  localparam int OP_PASS2 = 8;
  localparam int OP_MUL   = 9;

  localparam int COND_EQ = 0;
  localparam int COND_GT = 1;
  localparam int COND_LT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// Radix-2 shift-add multiplier producing the low W bits of a*b.
// The first partial product is folded into the start cycle, so done rises on the last of W-1 further steps.
module exec_mul_iter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = CW'(W - 1);
      a_d   = a << 1;
      b_d   = b >> 1;
      acc_d = b[0] ? a : '0;
    end else if (run_q) begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign done    = run_q && (cnt_q == CW'(1));
  assign product = acc_q;

endmodule

// File: rtl/exec_unit.sv
// Execute stage: registered decode inputs, opcode ALU, branch/jump resolution, dmem addressing.
// Define EXEC_UNIT_MUL_EN to add the stalling iterative multiplier.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int PC_WIDTH        = 12,
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int OP_WIDTH        = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [OP_WIDTH-1:0]        in_op,
  input  logic [2:0]                 in_cond,
  input  logic                       in_act_branch,
  input  logic                       in_act_jump,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic                       in_flush,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic [IALU_WORD_WIDTH-1:0] in_src1,
  input  logic [IALU_WORD_WIDTH-1:0] in_src2,
  input  logic [IALU_WORD_WIDTH-1:0] in_src3,
  output logic                       out_stall,
  output logic                       out_valid,
  output logic                       out_act_load_dmem,
  output logic                       out_act_store_dmem,
  output logic                       out_act_write_res_to_reg,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
  output logic [IALU_WORD_WIDTH-1:0] out_dmem_wr_word,
  output logic                       out_set_pc,
  output logic                       out_flush,
  output logic [PC_WIDTH-1:0]        out_branch_pc,
  output logic [1:0]                 out_mul_state
);

  localparam int W   = IALU_WORD_WIDTH;
  localparam int SHW = $clog2(W);

  logic                       valid_q, flush_q, br_q, jmp_q, ld_q, st_q, wr_q;
  logic [OP_WIDTH-1:0]        op_q;
  logic [2:0]                 cond_q;
  logic [PMEM_WORD_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]        pc_q;
  logic [REG_IDX_WIDTH-1:0]   idx_q;
  logic [W-1:0]               src1_q, src2_q, src3_q;

  logic         live;
  logic         mul_hold;
  logic [W-1:0] alu_res, res, cmp;
  logic         taken;
  logic [SHW-1:0] sh;

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      br_q    <= 1'b0;
      jmp_q   <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      wr_q    <= 1'b0;
      op_q    <= '0;
      cond_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      idx_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      src3_q  <= '0;
    end else if (!out_stall) begin
      valid_q <= in_valid;
      flush_q <= in_flush;
      br_q    <= in_act_branch;
      jmp_q   <= in_act_jump;
      ld_q    <= in_act_load_dmem;
      st_q    <= in_act_store_dmem;
      wr_q    <= in_act_write_res_to_reg;
      op_q    <= in_op;
      cond_q  <= in_cond;
      instr_q <= in_instr;
      pc_q    <= in_pc;
      idx_q   <= in_res_reg_idx;
      src1_q  <= in_src1;
      src2_q  <= in_src2;
      src3_q  <= in_src3;
    end
  end

  assign live = valid_q && !flush_q;

`ifdef EXEC_UNIT_MUL_EN
  mul_state_e   state_q, state_d;
  logic         is_mul, mul_start, mul_done;
  logic [W-1:0] mul_product;

  assign is_mul = (op_q == OP_WIDTH'(OP_MUL));

  exec_mul_iter #(.W(W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (src1_q),
    .b       (src2_q),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: if (live && is_mul) begin
        state_d   = ST_BUSY;
        mul_start = 1'b1;
      end
      ST_BUSY: if (mul_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Hold decode through the capture cycle and every BUSY step; release in DONE.
  assign out_stall     = ((state_q == ST_IDLE) && live && is_mul) || (state_q == ST_BUSY);
  assign mul_hold      = live && is_mul && (state_q != ST_DONE);
  assign out_mul_state = state_q;
`else
  assign out_stall     = 1'b0;
  assign mul_hold      = 1'b0;
  assign out_mul_state = ST_IDLE;
`endif

  assign sh  = src2_q[SHW-1:0];
  assign cmp = src1_q - src2_q;

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_WIDTH'(OP_ADD):   alu_res = src1_q + src2_q;
      OP_WIDTH'(OP_SUB):   alu_res = src1_q - src2_q;
      OP_WIDTH'(OP_AND):   alu_res = src1_q & src2_q;
      OP_WIDTH'(OP_OR):    alu_res = src1_q | src2_q;
      OP_WIDTH'(OP_XOR):   alu_res = src1_q ^ src2_q;
      OP_WIDTH'(OP_SHL):   alu_res = src1_q << sh;
      OP_WIDTH'(OP_SHR):   alu_res = src1_q >> sh;
      OP_WIDTH'(OP_SRA):   alu_res = $signed(src1_q) >>> sh;
      OP_WIDTH'(OP_PASS2): alu_res = src2_q;
`ifdef EXEC_UNIT_MUL_EN
      OP_WIDTH'(OP_MUL):   alu_res = mul_product;
`endif
      default:             alu_res = '0;
    endcase
  end

  assign taken = (cond_q[COND_EQ] && (cmp == '0))
              || (cond_q[COND_GT] && !cmp[W-1] && (cmp != '0))
              || (cond_q[COND_LT] && cmp[W-1]);

  assign res = br_q ? cmp : alu_res;

  always_comb begin
    out_valid                = 1'b0;
    out_act_load_dmem        = 1'b0;
    out_act_store_dmem       = 1'b0;
    out_act_write_res_to_reg = 1'b0;
    out_instr                = '0;
    out_pc                   = '0;
    out_res_reg_idx          = '0;
    out_res                  = '0;
    out_dmem_rd_addr         = '0;
    out_dmem_wr_addr         = '0;
    out_dmem_wr_word         = '0;
    out_set_pc               = 1'b0;
    out_flush                = 1'b0;
    out_branch_pc            = '0;
    if (live && !mul_hold) begin
      out_valid                = 1'b1;
      out_act_load_dmem        = ld_q;
      out_act_store_dmem       = st_q;
      out_act_write_res_to_reg = wr_q;
      out_instr                = instr_q;
      out_pc                   = pc_q;
      out_res_reg_idx          = idx_q;
      out_res                  = res;
      if (ld_q) out_dmem_rd_addr = res[DMEM_ADDR_WIDTH-1:0];
      if (st_q) begin
        out_dmem_wr_addr = res[DMEM_ADDR_WIDTH-1:0];
        out_dmem_wr_word = src3_q;
      end
      if (jmp_q) begin
        out_set_pc    = 1'b1;
        out_flush     = 1'b1;
        out_branch_pc = src3_q[PC_WIDTH-1:0];
      end else if (br_q && taken) begin
        out_set_pc    = 1'b1;
        out_flush     = 1'b1;
        out_branch_pc = pc_q + src3_q[PC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU ops, branch/jump redirect, dmem addressing, flush, reset and
// (with EXEC_UNIT_MUL_EN) the stalling multiplier.
module tb_exec_unit;
  import exec_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_act_branch, in_act_jump, in_act_load_dmem, in_act_store_dmem;
  logic        in_act_write_res_to_reg, in_flush;
  logic [3:0]  in_op;
  logic [2:0]  in_cond;
  logic [15:0] in_instr;
  logic [11:0] in_pc;
  logic [3:0]  in_res_reg_idx;
  logic [15:0] in_src1, in_src2, in_src3;
  logic        out_stall, out_valid, out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic [3:0]  out_res_reg_idx;
  logic [15:0] out_res;
  logic [11:0] out_dmem_rd_addr, out_dmem_wr_addr;
  logic [15:0] out_dmem_wr_word;
  logic        out_set_pc, out_flush;
  logic [11:0] out_branch_pc;
  logic [1:0]  out_mul_state;

  int total = 0;
  int bad   = 0;

  exec_unit dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_cond(in_cond),
    .in_act_branch(in_act_branch), .in_act_jump(in_act_jump),
    .in_act_load_dmem(in_act_load_dmem), .in_act_store_dmem(in_act_store_dmem),
    .in_act_write_res_to_reg(in_act_write_res_to_reg), .in_flush(in_flush),
    .in_instr(in_instr), .in_pc(in_pc), .in_res_reg_idx(in_res_reg_idx),
    .in_src1(in_src1), .in_src2(in_src2), .in_src3(in_src3),
    .out_stall(out_stall), .out_valid(out_valid),
    .out_act_load_dmem(out_act_load_dmem), .out_act_store_dmem(out_act_store_dmem),
    .out_act_write_res_to_reg(out_act_write_res_to_reg),
    .out_instr(out_instr), .out_pc(out_pc), .out_res_reg_idx(out_res_reg_idx),
    .out_res(out_res), .out_dmem_rd_addr(out_dmem_rd_addr), .out_dmem_wr_addr(out_dmem_wr_addr),
    .out_dmem_wr_word(out_dmem_wr_word), .out_set_pc(out_set_pc), .out_flush(out_flush),
    .out_branch_pc(out_branch_pc), .out_mul_state(out_mul_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_op = 0; in_cond = 0; in_act_branch = 0; in_act_jump = 0;
    in_act_load_dmem = 0; in_act_store_dmem = 0; in_act_write_res_to_reg = 0; in_flush = 0;
    in_instr = 0; in_pc = 0; in_res_reg_idx = 0; in_src1 = 0; in_src2 = 0; in_src3 = 0;
  endtask

  task automatic alu(input logic [3:0] op, input logic [15:0] s1, input logic [15:0] s2);
    idle();
    in_valid = 1; in_op = op; in_src1 = s1; in_src2 = s2; in_act_write_res_to_reg = 1;
    in_instr = 16'hA5C3; in_pc = 12'h123; in_res_reg_idx = 4'd7;
  endtask

  task automatic branch(input logic [2:0] cond, input logic [15:0] s1, input logic [15:0] s2,
                        input logic [11:0] pc, input logic [15:0] s3);
    idle();
    in_valid = 1; in_op = 4'(OP_SUB); in_act_branch = 1; in_cond = cond;
    in_src1 = s1; in_src2 = s2; in_pc = pc; in_src3 = s3;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_res"}, 32'(out_res), 0);
    check({tag, "_wr"}, 32'(out_act_write_res_to_reg), 0);
    check({tag, "_setpc"}, 32'(out_set_pc), 0);
    check({tag, "_stall"}, 32'(out_stall), 0);
  endtask

  initial begin
    int n;
    idle();
    reset = 0;
    alu(4'(OP_ADD), 16'h1111, 16'h2222);
    tick(); tick();
    check_quiet("reset");
    check("reset_pc", 32'(out_pc), 0);

    reset = 1;
    alu(4'(OP_ADD), 16'h7FFF, 16'h0001);
    tick();
    check("add_res", 32'(out_res), 32'h8000);
    check("add_valid", 32'(out_valid), 1);
    check("add_wr", 32'(out_act_write_res_to_reg), 1);
    check("add_pc", 32'(out_pc), 32'h123);
    check("add_idx", 32'(out_res_reg_idx), 7);
    check("add_instr", 32'(out_instr), 32'hA5C3);

    alu(4'(OP_SRA), 16'h8000, 16'h0003); tick(); check("sra", 32'(out_res), 32'hF000);
    alu(4'(OP_SUB), 16'h0003, 16'h0005); tick(); check("sub", 32'(out_res), 32'hFFFE);
    alu(4'(OP_SHR), 16'h8000, 16'h0004); tick(); check("shr", 32'(out_res), 32'h0800);
    alu(4'(OP_SHL), 16'h0003, 16'h0011); tick(); check("shl_mask", 32'(out_res), 32'h0006);
    alu(4'(OP_AND), 16'hF0F0, 16'hFF00); tick(); check("and", 32'(out_res), 32'hF000);
    alu(4'(OP_OR),  16'hF0F0, 16'hFF00); tick(); check("or",  32'(out_res), 32'hFFF0);
    alu(4'(OP_XOR), 16'hF0F0, 16'hFF00); tick(); check("xor", 32'(out_res), 32'h0FF0);
    alu(4'(OP_PASS2), 16'hDEAD, 16'h1234); tick(); check("pass2", 32'(out_res), 32'h1234);
    alu(4'hF, 16'h1234, 16'h1111); tick();
    check("undef_res", 32'(out_res), 0);
    check("undef_valid", 32'(out_valid), 1);

    // eq taken: 0x010 + 0xFF8 wraps to 0x008
    branch(3'b001, 16'd5, 16'd5, 12'h010, 16'hFFF8); tick();
    check("beq_setpc", 32'(out_set_pc), 1);
    check("beq_flush", 32'(out_flush), 1);
    check("beq_target", 32'(out_branch_pc), 32'h008);
    check("beq_res", 32'(out_res), 0);
    idle(); tick();
    check("beq_pulse_end", 32'(out_set_pc), 0);
    branch(3'b010, 16'd5, 16'd5, 12'h010, 16'hFFF8); tick();
    check("bgt_setpc", 32'(out_set_pc), 0);
    check("bgt_flush", 32'(out_flush), 0);
    check("bgt_valid", 32'(out_valid), 1);
    branch(3'b100, 16'd3, 16'd5, 12'h100, 16'h0020); tick();
    check("blt_setpc", 32'(out_set_pc), 1);
    check("blt_target", 32'(out_branch_pc), 32'h120);
    check("blt_res", 32'(out_res), 32'hFFFE);
    branch(3'b010, 16'd9, 16'd5, 12'h200, 16'h0004); tick();
    check("bgt_taken", 32'(out_branch_pc), 32'h204);

    idle(); in_valid = 1; in_act_jump = 1; in_src3 = 16'hFABC; in_pc = 12'h050; tick();
    check("jmp_setpc", 32'(out_set_pc), 1);
    check("jmp_flush", 32'(out_flush), 1);
    check("jmp_target", 32'(out_branch_pc), 32'hABC);

    idle(); in_valid = 1; in_op = 4'(OP_ADD); in_act_store_dmem = 1;
    in_src1 = 16'h0100; in_src2 = 16'h0004; in_src3 = 16'hBEEF; tick();
    check("st_wr_addr", 32'(out_dmem_wr_addr), 32'h104);
    check("st_wr_word", 32'(out_dmem_wr_word), 32'hBEEF);
    check("st_rd_addr", 32'(out_dmem_rd_addr), 0);
    check("st_act", 32'(out_act_store_dmem), 1);

    idle(); in_valid = 1; in_op = 4'(OP_ADD); in_act_load_dmem = 1;
    in_src1 = 16'h2000; in_src2 = 16'h0345; in_src3 = 16'h7777; tick();
    check("ld_rd_addr", 32'(out_dmem_rd_addr), 32'h345);
    check("ld_wr_addr", 32'(out_dmem_wr_addr), 0);
    check("ld_wr_word", 32'(out_dmem_wr_word), 0);
    check("ld_act", 32'(out_act_load_dmem), 1);

    alu(4'(OP_MUL), 16'h0123, 16'h0045); in_flush = 1; tick();
    check_quiet("flush_mul");
    tick();
    check("flush_mul_later_stall", 32'(out_stall), 0);
    idle(); tick();
    check_quiet("novalid");

`ifdef EXEC_UNIT_MUL_EN
    alu(4'(OP_MUL), 16'h0123, 16'h0045); tick();
    check("mul_capture_stall", 32'(out_stall), 1);
    check("mul_capture_valid", 32'(out_valid), 0);
    alu(4'(OP_ADD), 16'h0002, 16'h0003);
    n = 0;
    while (out_stall && n < 40) begin
      check("mul_busy_valid", 32'(out_valid), 0);
      check("mul_busy_wr", 32'(out_act_write_res_to_reg), 0);
      n++;
      tick();
    end
    check("mul_stall_cycles", 32'(n), 16);
    check("mul_done_valid", 32'(out_valid), 1);
    check("mul_done_res", 32'(out_res), 32'h4E6F);
    check("mul_done_wr", 32'(out_act_write_res_to_reg), 1);
    tick();
    check("mul_next_add", 32'(out_res), 32'h0005);
    check("mul_next_valid", 32'(out_valid), 1);
    check("mul_next_stall", 32'(out_stall), 0);

    alu(4'(OP_MUL), 16'h0123, 16'h0045); tick();
    idle();
    repeat (5) tick();
    check("mul_mid_stall", 32'(out_stall), 1);
    reset = 0; tick();
    check_quiet("mul_reset");
    check("mul_reset_state", 32'(out_mul_state), 0);
    reset = 1;
    alu(4'(OP_ADD), 16'h0010, 16'h0020); tick();
    check("post_reset_add", 32'(out_res), 32'h0030);
    check("post_reset_valid", 32'(out_valid), 1);
    check("post_reset_stall", 32'(out_stall), 0);
`else
    alu(4'(OP_MUL), 16'h0123, 16'h0045); tick();
    check("mul_off_res", 32'(out_res), 0);
    check("mul_off_valid", 32'(out_valid), 1);
    check("mul_off_wr", 32'(out_act_write_res_to_reg), 1);
    check("mul_off_stall", 32'(out_stall), 0);
    alu(4'(OP_ADD), 16'h0002, 16'h0003); tick();
    check("mul_off_next", 32'(out_res), 32'h0005);
    reset = 0; tick();
    check_quiet("late_reset");
    reset = 1;
    alu(4'(OP_ADD), 16'h0010, 16'h0020); tick();
    check("post_reset_add", 32'(out_res), 32'h0030);
`endif

    idle(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
